// File: rtl/pc_seq_ctrl_if.sv
// Request channel between instruction decode (master) and the PC-bank
// control-flow sequencer (slave): valid/ready request plus done/rej status.
interface pc_seq_ctrl_if #(
  parameter int ADDR_W = 9
) ();
  logic              req_valid;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_target;
  logic              req_ready;
  logic              done;
  logic              rej;

  modport master (
    output req_valid, req_op, req_target,
    input  req_ready, done, rej
  );

  modport slave (
    input  req_valid, req_op, req_target,
    output req_ready, done, rej
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Control-flow sequencer for the PC bank. Each accepted request (STEP, JUMP,
// CALL, RET) is expanded into a sequence of cycles with exactly one bank
// strobe per cycle. A shadow frame pointer rejects CALL overflow and RET
// underflow before any strobe reaches the bank. All outputs are registered;
// since the strobe registers are loaded from the next state, they are always
// the Moore decode of the current state.
module pc_seq_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int DEPTH_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_seq_ctrl_if.slave       bus,
  output logic               inc,
  output logic               inc_pc_ref,
  output logic               dec_pc_ref,
  output logic               pc_set,
  output logic [ADDR_W-1:0]  pc_set_value,
  output logic [DEPTH_W-1:0] depth,
  output logic               err
);

  localparam logic [DEPTH_W-1:0] MAX_DEPTH  = {DEPTH_W{1'b1}};
  localparam logic [DEPTH_W-1:0] ZERO_DEPTH = {DEPTH_W{1'b0}};
  localparam logic [DEPTH_W-1:0] ONE_DEPTH  = {{(DEPTH_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] OP_STEP = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STEP   = 3'd1,
    JUMP   = 3'd2,
    C_ADV  = 3'd3,
    C_PUSH = 3'd4,
    C_SET  = 3'd5,
    RET    = 3'd6
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               latch_s;
  logic               reject_s;
  logic               ready_r;
  logic               done_r;
  logic               rej_r;
  logic [3:0]         strobe_r;
  logic [ADDR_W-1:0]  pcv_r;
  logic [DEPTH_W-1:0] depth_r;
  logic               err_r;

  // Strobe pattern {inc, inc_pc_ref, dec_pc_ref, pc_set} for a state; one-hot or zero.
  function automatic logic [3:0] strobes_of(input state_t s);
    case (s)
      STEP:    strobes_of = 4'b1000;
      C_ADV:   strobes_of = 4'b1000;
      C_PUSH:  strobes_of = 4'b0100;
      RET:     strobes_of = 4'b0010;
      JUMP:    strobes_of = 4'b0001;
      C_SET:   strobes_of = 4'b0001;
      default: strobes_of = 4'b0000;
    endcase
  endfunction

  // States in which the request completes successfully.
  function automatic logic is_final(input state_t s);
    case (s)
      STEP, JUMP, C_SET, RET: is_final = 1'b1;
      default:                is_final = 1'b0;
    endcase
  endfunction

  // Next-state logic: accept in IDLE, reject on frame overflow/underflow, walk the CALL sequence.
  always_comb begin
    state_s  = state_r;
    latch_s  = 1'b0;
    reject_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          case (bus.req_op)
            OP_STEP: state_s = STEP;
            OP_JUMP: begin
              state_s = JUMP;
              latch_s = 1'b1;
            end
            OP_CALL: begin
              latch_s = 1'b1;
              if (depth_r != MAX_DEPTH) begin
                state_s = C_ADV;
              end else begin
                reject_s = 1'b1;
              end
            end
            OP_RET: begin
              if (depth_r != ZERO_DEPTH) begin
                state_s = RET;
              end else begin
                reject_s = 1'b1;
              end
            end
            default: state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      STEP:    state_s = IDLE;
      JUMP:    state_s = IDLE;
      C_ADV:   state_s = C_PUSH;
      C_PUSH:  state_s = C_SET;
      C_SET:   state_s = IDLE;
      RET:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered handshake/strobe outputs, decoded from the state about to be entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
      rej_r    <= 1'b0;
      strobe_r <= 4'b0000;
    end else begin
      ready_r  <= (state_s == IDLE);
      done_r   <= is_final(state_s) | reject_s;
      rej_r    <= reject_s;
      strobe_r <= strobes_of(state_s);
    end
  end

  // Target latch, shadow frame pointer (moves at the end of push/pop cycles) and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcv_r   <= {ADDR_W{1'b0}};
      depth_r <= ZERO_DEPTH;
      err_r   <= 1'b0;
    end else begin
      if (latch_s) begin
        pcv_r <= bus.req_target;
      end
      if (state_r == C_PUSH) begin
        depth_r <= depth_r + ONE_DEPTH;
      end else if (state_r == RET) begin
        depth_r <= depth_r - ONE_DEPTH;
      end
      err_r <= err_r | reject_s;
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.done      = done_r;
  assign bus.rej       = rej_r;
  assign inc           = strobe_r[3];
  assign inc_pc_ref    = strobe_r[2];
  assign dec_pc_ref    = strobe_r[1];
  assign pc_set        = strobe_r[0];
  assign pc_set_value  = pcv_r;
  assign depth         = depth_r;
  assign err           = err_r;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Testbench for pc_seq_ctrl: directed scenarios plus randomized requests
// checked cycle by cycle against a request-level model (expected strobe
// sequence per op, frame count, sticky error, latched target).
module tb_pc_seq_ctrl;
  localparam int AW = 9;
  localparam int DW = 3;
  localparam logic [1:0] OP_STEP = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  // Observed vector layout: {inc, inc_pc_ref, dec_pc_ref, pc_set, done, rej, req_ready}
  localparam logic [6:0] V_IDLE   = 7'b0000001;
  localparam logic [6:0] V_STEP   = 7'b1000100;
  localparam logic [6:0] V_ADV    = 7'b1000000;
  localparam logic [6:0] V_PUSH   = 7'b0100000;
  localparam logic [6:0] V_SETDN  = 7'b0001100;
  localparam logic [6:0] V_POPDN  = 7'b0010100;
  localparam logic [6:0] V_REJ    = 7'b0000111;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inc, inc_pc_ref, dec_pc_ref, pc_set, err;
  logic [AW-1:0] pc_set_value;
  logic [DW-1:0] depth;

  pc_seq_ctrl_if #(.ADDR_W(AW)) bus ();

  pc_seq_ctrl #(.ADDR_W(AW), .DEPTH_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .inc          (inc),
    .inc_pc_ref   (inc_pc_ref),
    .dec_pc_ref   (dec_pc_ref),
    .pc_set       (pc_set),
    .pc_set_value (pc_set_value),
    .depth        (depth),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int            m_depth;
  logic          m_err;
  logic [AW-1:0] m_pcv;

  function automatic logic [6:0] obs();
    return {inc, inc_pc_ref, dec_pc_ref, pc_set, bus.done, bus.rej, bus.req_ready};
  endfunction

  task automatic model_reset();
    m_depth = 0;
    m_err   = 1'b0;
    m_pcv   = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one request from an idle negedge, check every cycle of its expansion
  // and the settled idle cycle after it. Ends on a negedge with the DUT idle.
  task automatic run_req(input logic [1:0] op, input logic [AW-1:0] tgt, input string tag);
    logic [6:0] exp_q[$];
    int         guard;
    int         new_depth;
    logic       new_err;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (guard >= 20) begin
      n_fail++;
      $display("FAIL %s ready_timeout: req_ready=%b required 1", tag, bus.req_ready);
      return;
    end
    new_depth = m_depth;
    new_err   = m_err;
    if (op == OP_JUMP || op == OP_CALL) m_pcv = tgt;
    case (op)
      OP_STEP: exp_q = '{V_STEP};
      OP_JUMP: exp_q = '{V_SETDN};
      OP_CALL: begin
        if (m_depth == 7) begin
          exp_q = '{V_REJ};
          new_err = 1'b1;
        end else begin
          exp_q = '{V_ADV, V_PUSH, V_SETDN};
          new_depth = m_depth + 1;
        end
      end
      default: begin
        if (m_depth == 0) begin
          exp_q = '{V_REJ};
          new_err = 1'b1;
        end else begin
          exp_q = '{V_POPDN};
          new_depth = m_depth - 1;
        end
      end
    endcase
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_target = tgt;
    @(posedge clk);
    foreach (exp_q[i]) begin
      @(negedge clk);
      n_tests++;
      if (obs() !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cycle%0d strobes: got %b required %b", tag, i + 1, obs(), exp_q[i]);
      end
      if (exp_q[i][3]) begin
        n_tests++;
        if (pc_set_value !== m_pcv) begin
          n_fail++;
          $display("FAIL %s pc_set_value: got %h required %h", tag, pc_set_value, m_pcv);
        end
      end
      if (i == 0) bus.req_valid = 1'b0;
    end
    m_depth = new_depth;
    m_err   = new_err;
    @(negedge clk);
    n_tests++;
    if ({obs(), depth, err, pc_set_value} !== {V_IDLE, DW'(m_depth), m_err, m_pcv}) begin
      n_fail++;
      $display("FAIL %s settle: got strb=%b depth=%0d err=%b pcv=%h required strb=%b depth=%0d err=%b pcv=%h",
               tag, obs(), depth, err, pc_set_value, V_IDLE, m_depth, m_err, m_pcv);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({obs(), depth, err, pc_set_value} !== {V_IDLE, 3'd0, 1'b0, 9'h000}) begin
      n_fail++;
      $display("FAIL reset_hold: got strb=%b depth=%0d err=%b pcv=%h required strb=%b 0 0 000",
               obs(), depth, err, pc_set_value, V_IDLE);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({obs(), depth, err} !== {V_IDLE, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release: got strb=%b depth=%0d err=%b required strb=%b 0 0",
               obs(), depth, err, V_IDLE);
    end
  endtask

  task automatic test_ret_at_zero();
    run_req(OP_RET, 9'h000, "ret_at_zero");
  endtask

  // req_valid held high for three STEP accepts: inc/done on odd cycles only.
  task automatic test_back_to_back();
    logic [6:0] e;
    bus.req_valid  = 1'b1;
    bus.req_op     = OP_STEP;
    bus.req_target = 9'h0AA;
    @(posedge clk);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      e = (i % 2 == 1) ? V_STEP : V_IDLE;
      n_tests++;
      if (obs() !== e || depth !== DW'(m_depth)) begin
        n_fail++;
        $display("FAIL back_to_back cycle%0d: got %b depth=%0d required %b depth=%0d",
                 i, obs(), depth, e, m_depth);
      end
      if (i == 5) bus.req_valid = 1'b0;
    end
  endtask

  task automatic test_jump();
    run_req(OP_JUMP, 9'h1A5, "jump_1a5");
  endtask

  task automatic test_call();
    run_req(OP_CALL, 9'h040, "call_040");
  endtask

  task automatic test_overflow_underflow();
    while (m_depth < 7) run_req(OP_CALL, 9'(m_depth * 37 + 5), "call_fill");
    run_req(OP_CALL, 9'h155, "call_overflow");
    while (m_depth > 0) run_req(OP_RET, 9'h000, "ret_drain");
    run_req(OP_RET, 9'h000, "ret_underflow");
  endtask

  task automatic test_random();
    logic [1:0] op;
    for (int k = 0; k < 80; k++) begin
      op = 2'($urandom_range(0, 3));
      run_req(op, 9'($urandom), "random");
    end
  endtask

  // Reset asserted mid-CALL while inc_pc_ref is high: everything drops at once.
  task automatic test_reset_mid_call();
    if (m_depth == 7) run_req(OP_RET, 9'h000, "pre_ret");
    bus.req_valid  = 1'b1;
    bus.req_op     = OP_CALL;
    bus.req_target = 9'h0F0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    n_tests++;
    if (obs() !== V_PUSH) begin
      n_fail++;
      $display("FAIL mid_reset_push: got %b required %b", obs(), V_PUSH);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({obs(), depth, err, pc_set_value} !== {V_IDLE, 3'd0, 1'b0, 9'h000}) begin
      n_fail++;
      $display("FAIL mid_reset_drop: got strb=%b depth=%0d err=%b pcv=%h required strb=%b 0 0 000",
               obs(), depth, err, pc_set_value, V_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_req(OP_STEP, 9'h000, "step_after_reset");
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_target = '0;
    model_reset();
    test_reset();
    test_ret_at_zero();
    test_back_to_back();
    test_jump();
    test_call();
    test_overflow_underflow();
    apply_reset();
    @(negedge clk);
    test_random();
    test_reset_mid_call();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Control-flow sequencer that drives the PC bank's control strobes: inc, inc_pc_ref, dec_pc_ref, pc_set, pc_set_value.
- Accepts one control-flow request at a time (STEP, JUMP, CALL, RET) over a valid/ready handshake.
- Expands each request into the ordered single-strobe cycle sequence the bank requires.
- Keeps a shadow copy of the bank's frame pointer so overflow and underflow are rejected before any strobe is issued.
- Sits between instruction decode and the PC bank.

Parameters:
- ADDR_W, 9, width of PC values and jump/call targets.
- DEPTH_W, 3, frame-pointer width; MAX_DEPTH = 2**DEPTH_W - 1 = 7.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_op  in  2  00 STEP, 01 JUMP, 10 CALL, 11 RET.
- req_target  in  ADDR_W  target for JUMP/CALL; ignored otherwise.
- req_ready  out  1  sequencer can accept a request.
- done  out  1  one-cycle pulse: request finished or rejected.
- rej  out  1  one-cycle pulse with done when a request was rejected.
- inc  out  1  advance the PC of the current frame.
- inc_pc_ref  out  1  push frame (frame pointer +1).
- dec_pc_ref  out  1  pop frame (frame pointer -1).
- pc_set  out  1  load pc_set_value into the current frame.
- pc_set_value  out  ADDR_W  latched target.
- depth  out  DEPTH_W  shadow frame pointer.
- err  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; depth=0, err=0, pc_set_value=0.
  - All strobes, done and rej are 0; req_ready=1.
  - Reset mid-sequence abandons the sequence immediately with no further strobes.
  - Integration requirement: the PC bank must be reset or initialised in the same window so that depth matches the bank's frame pointer.
- FSM states: IDLE, STEP, JUMP, C_ADV, C_PUSH, C_SET, RET.
- req_ready = 1 only in IDLE. A request is accepted on a rising edge where req_valid && req_ready.
- At acceptance, req_target is latched into pc_set_value; the value holds until the next accepted JUMP/CALL.
- Transitions from IDLE on acceptance:
  - STEP -> STEP.
  - JUMP -> JUMP.
  - CALL with depth < MAX_DEPTH -> C_ADV.
  - CALL with depth == MAX_DEPTH -> stays IDLE. Next cycle: done=1, rej=1; err set; no strobe issued.
  - RET with depth > 0 -> RET.
  - RET with depth == 0 -> stays IDLE. Next cycle: done=1, rej=1; err set; no strobe issued.
- Strobes are Moore outputs of the state; at most one strobe is high in any cycle:
  - STEP: inc=1, done=1 -> IDLE.
  - JUMP: pc_set=1, done=1 -> IDLE.
  - C_ADV: inc=1. The caller PC advances so the saved frame holds the return address. -> C_PUSH.
  - C_PUSH: inc_pc_ref=1; depth increments at the end of this cycle. -> C_SET.
  - C_SET: pc_set=1, done=1. The target is written into the new frame. -> IDLE.
  - RET: dec_pc_ref=1, done=1; depth decrements at the end of this cycle. -> IDLE.
- Latency from the acceptance edge to done: 1 cycle for STEP, JUMP, RET and rejects; 3 cycles for CALL.
- Throughput: the next request can be accepted on the edge that ends the done cycle, giving back-to-back STEPs every 2 cycles.
- The one-strobe-per-cycle rule is mandatory because the bank gives pc_set priority over inc, and a same-cycle pc_set with inc_pc_ref would write the old frame.
- err is sticky until reset. Requests continue to be served while err=1.
- depth never wraps: it is bounded to 0..MAX_DEPTH by the reject rule.
- While busy, req_valid and req_op/req_target are ignored. The requester holds them until accepted.

Test Plan:
- Reset, then STEP with req_valid held 1 for 3 accepts -> inc pulses at cycles 1, 3, 5 after the first edge; done coincides with each; depth=0; no other strobes.
- JUMP target=9'h1A5 -> one cycle with pc_set=1 and pc_set_value=9'h1A5; inc=0 that cycle; done=1.
- CALL target=9'h040 from depth 0 -> consecutive cycles show inc, then inc_pc_ref, then pc_set (value 9'h040, done=1); depth=1 after; req_ready low for those 3 cycles.
- 7 CALLs then an 8th CALL -> 8th gives done=rej=1 with no strobes; err=1; depth stays 7. Then 7 RETs -> dec_pc_ref pulses; depth=0. A further RET is rejected, err stays 1.
- RET at depth 0 straight after reset -> rej=1, err=1, no dec_pc_ref.
- Assert rst_n=0 during C_PUSH -> all strobes drop asynchronously; depth=0, err=0, req_ready=1; the following STEP behaves normally.
